aes_cipher_core: RTL

- Iterative AES-128 encryption datapath. Sits directly downstream of the expanded-key generator.
- Consumes its 1408-bit round-key bus (round10..round0) and its one-cycle `done` pulse.
- Encrypts one 128-bit block per request with ready/valid handshakes on both sides.
- Executes one full round per clock. The result block is presented to the AXI wrapper's output register.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_cipher_core_round.sv | 31 +++
 rtl/aes_cipher_core.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helper functions.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_BLK_W  = 128;
    localparam int AES_EKEY_W = 1408;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // S-box packed MSB-first: entry 0x00 occupies bits [2047:2040].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 run from MSB to LSB (row 0 in the top byte).
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i sits at [127-8i -: 8]; row = i mod 4, column = i div 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127 - 8*i -: 8] = s[127 - 8*src -: 8];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_cipher_core_round.sv
// One full AES round, purely combinational; MixColumns bypassed on the last round.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;

    // SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey
    always_comb begin
        sub_bytes = '0;
        for (int i = 0; i < 16; i++) begin
            sub_bytes[8*i +: 8] = sbox(state[8*i +: 8]);
        end
        shifted = shift_rows(sub_bytes);
        mixed   = shifted;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
            end
        end
        next_state = mixed ^ round_key;
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor: one round per clock, ready/valid on both sides.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sys_en,
    input  logic            key_start,
    input  logic            key_done,
    input  logic [1407:0]   expandedkey,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic            busy
);

    aes_state_e   state_q,     state_d;
    logic [127:0] st_q,        st_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [127:0] out_data_q,  out_data_d;
    logic         key_ok_q,    key_ok_d;

    logic [127:0] round_key;
    logic         last_round;
    logic [127:0] round_out;

    // Round key picked straight off the expanded-key bus by the current round index.
    always_comb begin
        round_key  = expandedkey[128*int'(round_cnt_q) +: 128];
        last_round = (round_cnt_q == 4'(NR));
    end

    aes_round_comb u_round (
        .state      (st_q),
        .round_key  (round_key),
        .last       (last_round),
        .next_state (round_out)
    );

    assign in_ready  = (state_q == ST_IDLE) && key_ok_q && sys_en;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

    // Next-state logic; sys_en low leaves every register at its current value.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        round_cnt_d = round_cnt_q;
        out_data_d  = out_data_q;
        key_ok_d    = key_ok_q;
        if (sys_en) begin
            if (key_start) begin
                key_ok_d = 1'b0;
            end else if (key_done) begin
                key_ok_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        st_d        = in_data ^ expandedkey[127:0];
                        round_cnt_d = 4'd1;
                        state_d     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    st_d        = round_out;
                    round_cnt_d = round_cnt_q + 4'd1;
                    if (last_round) begin
                        out_data_d  = round_out;
                        round_cnt_d = 4'd0;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            st_q        <= '0;
            round_cnt_q <= '0;
            out_data_q  <= '0;
            key_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            round_cnt_q <= round_cnt_d;
            out_data_q  <= out_data_d;
            key_ok_q    <= key_ok_d;
        end
    end

endmodule
